// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the driver (master) and the word-memory completer (slave).
interface apb_slave_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              PSel;
    logic              PEnable;
    logic              PWrite;
    logic [ADDR_W-1:0] PAddr;
    logic [DATA_W-1:0] PWData;
    logic [DATA_W-1:0] PRData;
    logic              PReady;
    logic              PSlverr;

    modport master (
        output PSel, PEnable, PWrite, PAddr, PWData,
        input  PRData, PReady, PSlverr
    );

    modport slave (
        input  PSel, PEnable, PWrite, PAddr, PWData,
        output PRData, PReady, PSlverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word memory. A setup phase latches the request, an
// optional run of wait states follows, then PReady/PSlverr/PRData are presented
// from registers. Writes commit on the completing edge; out-of-range addresses
// answer with PSlverr and never touch the array.
module apb_slave_mem #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 Rst,
    apb_slave_mem_if.slave       bus,
    output logic [15:0]          xfer_cnt
);
    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Word storage; deliberately outside the reset domain so data survives Rst.
    logic [DATA_W-1:0] memory [DEPTH];

    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              write_q,   write_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [3:0]        wcnt_q,    wcnt_d;
    logic [DATA_W-1:0] prdata_q,  prdata_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;
    logic [15:0]       xcnt_q,    xcnt_d;
    logic              mem_we;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    // Read data presented with PReady: memory word for an in-range read, else zero.
    function automatic logic [DATA_W-1:0] resp_data(input logic [ADDR_W-1:0] a,
                                                    input logic              w);
        return (!w && in_range(a)) ? memory[idx(a)] : '0;
    endfunction

    // Next-state and response logic for the IDLE/ACCESS transfer FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wcnt_d    = wcnt_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        xcnt_d    = xcnt_q;
        mem_we    = 1'b0;

        if (bus.PSel && !bus.PEnable) begin
            // Setup phase, also accepted mid-ACCESS as a restart.
            state_d   = ACCESS;
            addr_d    = bus.PAddr;
            write_d   = bus.PWrite;
            wdata_d   = bus.PWData;
            wcnt_d    = WS;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            if (WAIT_STATES == 0) begin
                pready_d  = 1'b1;
                pslverr_d = !in_range(bus.PAddr);
                prdata_d  = resp_data(bus.PAddr, bus.PWrite);
            end
        end else if (state_q == ACCESS) begin
            if (!bus.PSel) begin
                // Master abandoned the transfer: nothing written, nothing counted.
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end else if (pready_q) begin
                mem_we    = write_q && in_range(addr_q);
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                xcnt_d    = xcnt_q + 16'd1;
            end else begin
                wcnt_d = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
                if (wcnt_q <= 4'd1) begin
                    pready_d  = 1'b1;
                    pslverr_d = !in_range(addr_q);
                    prdata_d  = resp_data(addr_q, write_q);
                end
            end
        end
    end

    // Control and response registers, cleared asynchronously by Rst.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wcnt_q    <= 4'd0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            xcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wcnt_q    <= wcnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            xcnt_q    <= xcnt_d;
        end
    end

    // Commit the latched write on the completing edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            memory[idx(addr_q)] <= wdata_q;
        end
    end

    assign bus.PRData  = prdata_q;
    assign bus.PReady  = pready_q;
    assign bus.PSlverr = pslverr_q;
    assign xfer_cnt    = xcnt_q;
endmodule
